// File: rtl/seg7_pkg.sv
// Shared glyph constants, segment type and reader FSM states
// for the two-digit 7-segment pair reader.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // bit6..0 = g f e d c b a, active-high
  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational single-glyph decoder: segment code to digit,
// with blank and illegal-code flags.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] digit,
  output logic       is_blank,
  output logic       is_illegal
);

  always_comb begin
    digit      = 4'd0;
    is_blank   = 1'b0;
    is_illegal = 1'b0;
    case (glyph)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_pair_reader.sv
// Samples a tens/units segment pair, waits for it to settle,
// decodes it and hands one result per stable pattern downstream.
module seg7_pair_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_VALUE     = 81
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_units,
  input  logic [6:0] seg_tens,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] value,
  output logic       blank,
  output logic       err,
  output logic       overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [7:0]    VAL_MAX = 8'(MAX_VALUE);

  logic [13:0]   s;
  logic [13:0]   s_prev;
  logic          s_valid;
  logic          prev_valid;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          changed;
  logic          capture;
  state_t        state;
  state_t        state_next;

  logic [3:0] u_digit;
  logic [3:0] t_digit;
  logic       u_blank;
  logic       t_blank;
  logic       u_ill;
  logic       t_ill;
  logic [7:0] sum;
  logic [7:0] c_value;
  logic       c_blank;
  logic       c_err;

  // s_valid/prev_valid keep reset zeros from posing as a stable sample
  always_ff @(posedge clk) begin
    if (rst) begin
      s          <= '0;
      s_prev     <= '0;
      s_valid    <= 1'b0;
      prev_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      s          <= {seg_tens, seg_units};
      s_prev     <= s;
      s_valid    <= 1'b1;
      prev_valid <= s_valid;
      cnt        <= cnt_next;
    end
  end

  always_comb begin
    changed  = (s != s_prev) || !prev_valid;
    cnt_next = cnt;
    if (changed)
      cnt_next = CNT_ONE;
    else if (cnt != CNT_MAX)
      cnt_next = cnt + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= TRACK;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (capture)
      state_next = HOLD;
    else if (changed)
      state_next = TRACK;
  end

  always_comb begin
    capture = s_valid && (cnt_next == CNT_MAX) &&
              ((state == TRACK) || changed);
  end

  seg7_glyph_decode u_dec_units (
    .glyph      (s[6:0]),
    .digit      (u_digit),
    .is_blank   (u_blank),
    .is_illegal (u_ill)
  );

  seg7_glyph_decode u_dec_tens (
    .glyph      (s[13:7]),
    .digit      (t_digit),
    .is_blank   (t_blank),
    .is_illegal (t_ill)
  );

  always_comb begin
    sum     = {4'd0, t_digit} * 8'd10 + {4'd0, u_digit};
    c_blank = u_blank && t_blank;
    c_err   = !c_blank &&
              (u_ill || t_ill || u_blank || t_blank || (sum > VAL_MAX));
    c_value = (c_blank || c_err) ? 8'd0 : sum;
  end

  // Accept on the capture edge frees the slot for the new result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      value     <= 8'd0;
      blank     <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
    end else if (capture) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        value     <= c_value;
        blank     <= c_blank;
        err       <= c_err;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_pair_reader.sv
// Scoreboard bench for seg7_pair_reader: directed patterns,
// expected results queued at stimulus time, popped by a monitor.
module tb_seg7_pair_reader;
  import seg7_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_units = SEG_BLANK;
  logic [6:0] seg_tens = SEG_BLANK;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] value;
  logic       blank;
  logic       err;
  logic       overrun;

  typedef struct packed {
    logic [7:0] v;
    logic       b;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;

  seg7_pair_reader #(
    .STABLE_CYCLES (4),
    .MAX_VALUE     (81)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_units (seg_units),
    .seg_tens  (seg_tens),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .value     (value),
    .blank     (blank),
    .err       (err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req)
      passed++;
    else
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input seg_t t, input seg_t u);
    seg_tens  = t;
    seg_units = u;
  endtask

  task automatic expect_out(input int v, input logic b, input logic e);
    exp_t x;
    x.v = 8'(v);
    x.b = b;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      step(1);
      n++;
    end
    total++;
    if (sb.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL %s timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every accepted result must match the queue head
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_out actual=%0d/%0d/%0d required=none",
                 value, blank, err);
      end else begin
        e = sb.pop_front();
        chk("result", int'({value, blank, err}), int'(e));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    put(SEG_3, SEG_8);
    step(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_value", value, 0);
    chk("rst_overrun", overrun, 0);

    rst = 1'b0;
    expect_out(38, 1'b0, 1'b0);
    step(4);
    chk("lat_before", out_valid, 0);
    step(1);
    chk("lat_at", out_valid, 1);
    drain("drain_38");

    put(SEG_8, SEG_1);
    expect_out(81, 1'b0, 1'b0);
    drain("drain_81");

    put(SEG_8, SEG_2);
    expect_out(0, 1'b0, 1'b1);
    drain("drain_82");

    put(SEG_BLANK, SEG_BLANK);
    expect_out(0, 1'b1, 1'b0);
    drain("drain_blank");

    put(SEG_BLANK, SEG_0);
    expect_out(0, 1'b0, 1'b1);
    drain("drain_mixed");

    put(7'b1110000, SEG_4);
    expect_out(0, 1'b0, 1'b1);
    drain("drain_illegal");

    for (int i = 0; i < 10; i++) begin
      put(SEG_2, (i % 2 == 0) ? SEG_5 : SEG_6);
      step(2);
    end
    put(SEG_2, SEG_6);
    expect_out(26, 1'b0, 1'b0);
    drain("drain_26");

    out_ready = 1'b0;
    put(SEG_1, SEG_2);
    expect_out(12, 1'b0, 1'b0);
    step(8);
    chk("hold_valid", out_valid, 1);
    chk("hold_value", value, 12);
    chk("no_overrun_yet", overrun, 0);
    put(SEG_4, SEG_7);
    step(8);
    chk("ovr_value", value, 12);
    chk("ovr_flag", overrun, 1);
    out_ready = 1'b1;
    step(1);
    chk("ovr_accepted", out_valid, 0);
    drain("drain_12");

    put(SEG_5, SEG_5);
    step(3);
    rst = 1'b1;
    step(1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_value", value, 0);
    chk("mid_rst_overrun", overrun, 0);
    rst = 1'b0;
    expect_out(55, 1'b0, 1'b0);
    drain("drain_55");

    step(20);
    chk("idle_queue", sb.size(), 0);
    chk("idle_valid", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
